// File: rtl/bist_engine_pkg.sv
// Shared definitions for the BIST engine: state encoding, LFSR/MISR tap masks and default seed.
package bist_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CHECK = 2'd3
  } bist_state_e;

  // LFSR taps sit on the low 16 bits (right-shifting Fibonacci, x^16+x^14+x^13+x^11+1).
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;
  // MISR feedback taps sit on the top 16 bits of the signature register.
  localparam logic [15:0] MISR_TAP_MASK = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED  = 16'hACE1;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: clear has priority over the compaction update.
module bist_misr
  import bist_engine_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sig
);

  logic [DATA_W-1:0] sig_q;
  logic [DATA_W-1:0] sig_d;

  function automatic logic [DATA_W-1:0] misr_step(input logic [DATA_W-1:0] m,
                                                  input logic [DATA_W-1:0] d);
    logic fb;
    fb = ^(m[DATA_W-1 -: 16] & MISR_TAP_MASK);
    return {m[DATA_W-2:0], fb} ^ d;
  endfunction

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = misr_step(sig_q, din);
    end else begin
      sig_d = sig_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_engine.sv
// BIST engine: LFSR pattern generation into the datapath test mux, MISR compaction, golden compare.
// Optional feature macro BIST_FAULT_INJECT_EN adds the fault_inject input.
module bist_engine
  import bist_engine_pkg::*;
#(
  parameter int                NUM_PATTERNS = 64,
  parameter int                DUT_LATENCY  = 2,
  parameter int                DATA_W       = 16,
  parameter logic [DATA_W-1:0] LFSR_SEED    = DEFAULT_SEED,
  parameter logic [DATA_W-1:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_bist,
`ifdef BIST_FAULT_INJECT_EN
  input  logic              fault_inject,
`endif
  input  logic [DATA_W-1:0] dut_result,
  output logic              bist_mode,
  output logic [DATA_W-1:0] tp_a,
  output logic [DATA_W-1:0] tp_b,
  output logic              tp_sel_eq,
  output logic              bist_active,
  output logic              bist_pass
);

  localparam int MAX_CNT = (NUM_PATTERNS > DUT_LATENCY) ? NUM_PATTERNS : DUT_LATENCY;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int VW      = DUT_LATENCY;

  bist_state_e       state_q, state_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VW-1:0]     vld_q, vld_d;
  logic [DATA_W-1:0] tp_a_q, tp_a_d;
  logic [DATA_W-1:0] tp_b_q, tp_b_d;
  logic              tp_sel_q, tp_sel_d;
  logic              active_q, active_d;
  logic              mode_q, mode_d;
  logic              pass_q, pass_d;
  logic              fi_armed_q, fi_armed_d;
  logic              start_s;
  logic              issue_s;
  logic              capture_s;
  logic              fi_req_s;
  logic [DATA_W-1:0] cap_data_s;
  logic [DATA_W-1:0] misr_sig_s;

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] l);
    logic fb;
    fb = ^(l[15:0] & LFSR_TAP_MASK);
    return {fb, l[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] x);
    return {x[7:0], x[DATA_W-1:8]};
  endfunction

`ifdef BIST_FAULT_INJECT_EN
  assign fi_req_s = fault_inject;
`else
  assign fi_req_s = 1'b0;
`endif

  assign issue_s   = (state_q == ST_RUN);
  assign capture_s = vld_q[VW-1];

  // Next-state, pattern issue and result bookkeeping.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    tp_a_d     = tp_a_q;
    tp_b_d     = tp_b_q;
    tp_sel_d   = tp_sel_q;
    active_d   = active_q;
    mode_d     = mode_q;
    pass_d     = pass_q;
    fi_armed_d = fi_armed_q;
    start_s    = 1'b0;
    vld_d      = (vld_q << 1) | VW'(issue_s);
    if (capture_s) begin
      fi_armed_d = 1'b0;
    end else begin
      fi_armed_d = fi_armed_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_bist) begin
          start_s    = 1'b1;
          state_d    = ST_RUN;
          lfsr_d     = lfsr_step(LFSR_SEED);
          tp_a_d     = LFSR_SEED;
          tp_b_d     = byte_swap(LFSR_SEED);
          tp_sel_d   = 1'b0;
          cnt_d      = '0;
          active_d   = 1'b1;
          mode_d     = 1'b1;
          pass_d     = 1'b0;
          fi_armed_d = fi_req_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(NUM_PATTERNS - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          tp_a_d   = lfsr_q;
          tp_b_d   = byte_swap(lfsr_q);
          tp_sel_d = ~cnt_q[0];
          lfsr_d   = lfsr_step(lfsr_q);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DUT_LATENCY - 1)) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_CHECK: begin
        pass_d   = (misr_sig_s == GOLDEN_SIG);
        active_d = 1'b0;
        mode_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Only the first capture of a run sees the inverted bit 0.
  always_comb begin
    if (fi_armed_q) begin
      cap_data_s = dut_result ^ {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      cap_data_s = dut_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= LFSR_SEED;
      cnt_q      <= '0;
      vld_q      <= '0;
      tp_a_q     <= LFSR_SEED;
      tp_b_q     <= byte_swap(LFSR_SEED);
      tp_sel_q   <= 1'b0;
      active_q   <= 1'b0;
      mode_q     <= 1'b0;
      pass_q     <= 1'b0;
      fi_armed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      tp_a_q     <= tp_a_d;
      tp_b_q     <= tp_b_d;
      tp_sel_q   <= tp_sel_d;
      active_q   <= active_d;
      mode_q     <= mode_d;
      pass_q     <= pass_d;
      fi_armed_q <= fi_armed_d;
    end
  end

  bist_misr #(
    .DATA_W (DATA_W)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (start_s),
    .en  (capture_s),
    .din (cap_data_s),
    .sig (misr_sig_s)
  );

  assign bist_mode   = mode_q;
  assign tp_a        = tp_a_q;
  assign tp_b        = tp_b_q;
  assign tp_sel_eq   = tp_sel_q;
  assign bist_active = active_q;
  assign bist_pass   = pass_q;

endmodule

// File: tb/tb_bist_engine.sv
// Directed bench for bist_engine with a behavioural two-stage datapath and reference LFSR/MISR golden.
module tb_bist_engine;

  localparam int NP  = 8;
  localparam int LAT = 2;

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [15:0] misr_nx(input logic [15:0] m, input logic [15:0] d);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ d;
  endfunction

  // Altitude (sel=0) and battery (sel=1) equations of the behavioural datapath.
  function automatic logic [15:0] dp_eq(input logic [15:0] a, input logic [15:0] b, input logic sel);
    if (sel) return (a ^ b) + 16'h0101;
    else     return a - (b >> 2);
  endfunction

  function automatic logic [15:0] calc_golden();
    logic [15:0] l;
    logic [15:0] m;
    l = 16'hACE1;
    m = 16'h0000;
    for (int k = 0; k < NP; k++) begin
      m = misr_nx(m, dp_eq(l, {l[7:0], l[15:8]}, k[0]));
      l = lfsr_nx(l);
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD = calc_golden();

  logic        clk;
  logic        rst;
  logic        start_bist;
  logic [15:0] dut_result;
  logic        bist_mode;
  logic [15:0] tp_a;
  logic [15:0] tp_b;
  logic        tp_sel_eq;
  logic        bist_active;
  logic        bist_pass;
`ifdef BIST_FAULT_INJECT_EN
  logic        fault_inject;
`endif

  bist_engine #(
    .NUM_PATTERNS (NP),
    .DUT_LATENCY  (LAT),
    .DATA_W       (16),
    .LFSR_SEED    (16'hACE1),
    .GOLDEN_SIG   (GOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_bist  (start_bist),
`ifdef BIST_FAULT_INJECT_EN
    .fault_inject(fault_inject),
`endif
    .dut_result  (dut_result),
    .bist_mode   (bist_mode),
    .tp_a        (tp_a),
    .tp_b        (tp_b),
    .tp_sel_eq   (tp_sel_eq),
    .bist_active (bist_active),
    .bist_pass   (bist_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] pat [NP];
  logic        corrupt_en;
  logic [15:0] stage1_q;
  logic [15:0] stage2_q;

  // Behavioural datapath, optionally corrupting the result of pattern 5.
  always @(posedge clk) begin
    stage1_q <= dp_eq(tp_a, tp_b, tp_sel_eq) ^
                ((corrupt_en && tp_a == pat[5]) ? 16'h0004 : 16'h0000);
    stage2_q <= stage1_q;
  end
  assign dut_result = stage2_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic run_bist(input int repulse_at, input int rst_at, input bit chk_tp, output int len);
    @(negedge clk);
    start_bist = 1'b1;
    @(negedge clk);
    start_bist = 1'b0;
    check_val("active_c0", bist_active, 1);
    check_val("mode_c0", bist_mode, 1);
    check_val("pass_c0", bist_pass, 0);
    len = 0;
    while (bist_active && len < 100) begin
      if (chk_tp && len < NP) begin
        check_val($sformatf("tp_a[%0d]", len), tp_a, pat[len]);
        check_val($sformatf("tp_b[%0d]", len), tp_b, {pat[len][7:0], pat[len][15:8]});
        check_val($sformatf("sel[%0d]", len), tp_sel_eq, len % 2);
      end
      start_bist = (len == repulse_at);
      if (len == rst_at) begin
        rst = 1'b1;
        #1;
        check_val("rst_active", bist_active, 0);
        check_val("rst_mode", bist_mode, 0);
        check_val("rst_pass", bist_pass, 0);
        check_val("rst_sel", tp_sel_eq, 0);
        check_val("rst_tp_a", tp_a, 16'hACE1);
        check_val("rst_tp_b", tp_b, 16'hE1AC);
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      len++;
      @(negedge clk);
    end
    start_bist = 1'b0;
    check_val("mode_after", bist_mode, 0);
  endtask

  int len;

  initial begin
    rst        = 1'b1;
    start_bist = 1'b0;
    corrupt_en = 1'b0;
`ifdef BIST_FAULT_INJECT_EN
    fault_inject = 1'b0;
`endif
    pat[0] = 16'hACE1;
    for (int i = 1; i < NP; i++) pat[i] = lfsr_nx(pat[i-1]);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("idle_active", bist_active, 0);
      check_val("idle_pass", bist_pass, 0);
      check_val("idle_mode", bist_mode, 0);
    end
    check_val("idle_tp_a", tp_a, 16'hACE1);

    // 2: clean run with operand sequence checks
    run_bist(-1, -1, 1'b1, len);
    check_val("t2_len", len, NP + LAT + 1);
    check_val("t2_pass", bist_pass, 1);
    repeat (3) @(negedge clk);
    check_val("t2_pass_hold", bist_pass, 1);

    // 3: corrupted pattern 5
    corrupt_en = 1'b1;
    run_bist(-1, -1, 1'b0, len);
    corrupt_en = 1'b0;
    check_val("t3_len", len, NP + LAT + 1);
    check_val("t3_pass", bist_pass, 0);

    // 4: start re-pulsed mid-run is ignored
    run_bist(4, -1, 1'b0, len);
    check_val("t4_len", len, NP + LAT + 1);
    check_val("t4_pass", bist_pass, 1);
    repeat (2) @(negedge clk);
    check_val("t4_no_restart", bist_active, 0);

    // 5: reset mid-run, then a full run
    run_bist(-1, 6, 1'b0, len);
    check_val("t5_abort_len", len, 6);
    run_bist(-1, -1, 1'b1, len);
    check_val("t5_len", len, NP + LAT + 1);
    check_val("t5_pass", bist_pass, 1);

`ifdef BIST_FAULT_INJECT_EN
    // 6: fault injection
    fault_inject = 1'b1;
    run_bist(-1, -1, 1'b0, len);
    fault_inject = 1'b0;
    check_val("t6_fi_pass", bist_pass, 0);
    run_bist(-1, -1, 1'b0, len);
    check_val("t6_clean_pass", bist_pass, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
